status_reg: RTL

Processor status (P) register for the 6502 core. Sits on the far side of the ALU flag interface: it captures the ALU's registered CO/V/Z/N results under command from the microsequencer, and feeds carry (CI) and decimal mode (BCD) back into the ALU. It also produces the pushed P image for PHP/BRK/IRQ/NMI and the delayed interrupt mask used for IRQ sampling.

---
 rtl/status_reg_pkg.sv | 68 ++++++
 rtl/status_reg_if.sv | 33 +++
 rtl/status_irq_mask.sv | 56 +++++
 rtl/status_reg.sv | 116 +++++++++++
 4 files changed

// File: rtl/status_reg_pkg.sv
// -----------------------------------------------------------------------------
// cpu_status_pkg
// Shared definitions for the 6502 processor status (P) register slice:
//   - 4-bit flag-update command encodings issued by the microsequencer
//   - bit positions of each flag inside the pushed P image
//   - reset image value and the stored-flag record type
//   - helper that assembles the pushed P image from stored flags
// -----------------------------------------------------------------------------
package cpu_status_pkg;

  // Flag-update commands
  localparam logic [3:0] CMD_NOP   = 4'h0;
  localparam logic [3:0] CMD_NZ    = 4'h1;
  localparam logic [3:0] CMD_NZC   = 4'h2;
  localparam logic [3:0] CMD_NZCV  = 4'h3;
  localparam logic [3:0] CMD_BIT   = 4'h4;
  localparam logic [3:0] CMD_PLP   = 4'h5;
  localparam logic [3:0] CMD_CLC   = 4'h6;
  localparam logic [3:0] CMD_SEC   = 4'h7;
  localparam logic [3:0] CMD_CLI   = 4'h8;
  localparam logic [3:0] CMD_SEI   = 4'h9;
  localparam logic [3:0] CMD_CLD   = 4'hA;
  localparam logic [3:0] CMD_SED   = 4'hB;
  localparam logic [3:0] CMD_CLV   = 4'hC;
  localparam logic [3:0] CMD_INT   = 4'hD;
  // Z-only update (TSB/TRB) on CMOS builds, reserved otherwise
  localparam logic [3:0] CMD_ZONLY = 4'hE;

  // Bit positions within P
  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  // P image straight out of reset with B=0: only I and the constant bit 5
  localparam logic [7:0] P_RESET = 8'h24;

  // The six flags that are actually stored
  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } status_flags_t;

  // Assemble the pushed P image; bit 5 is hard-wired, bit 4 comes from the
  // sequencer because B is not a stored flag.
  function automatic logic [7:0] p_image(input status_flags_t f, input logic brk);
    logic [7:0] img;
    img      = 8'h00;
    img[P_N] = f.n;
    img[P_V] = f.v;
    img[P_U] = 1'b1;
    img[P_B] = brk;
    img[P_D] = f.d;
    img[P_I] = f.i;
    img[P_Z] = f.z;
    img[P_C] = f.c;
    return img;
  endfunction

endpackage

// File: rtl/status_reg_if.sv
// -----------------------------------------------------------------------------
// status_reg_if
// Bundle between the microsequencer/ALU side (master) and the status
// register (slave).
//   master drives : cmd, sync, alu_co, alu_v, alu_z, alu_n, DI, brk_push, irq_n
//   slave drives  : P, C, D, I, irq_req
// -----------------------------------------------------------------------------
interface status_reg_if;
  logic [3:0] cmd;
  logic       sync;
  logic       alu_co;
  logic       alu_v;
  logic       alu_z;
  logic       alu_n;
  logic [7:0] DI;
  logic       brk_push;
  logic       irq_n;
  logic [7:0] P;
  logic       C;
  logic       D;
  logic       I;
  logic       irq_req;

  modport master (
    output cmd, sync, alu_co, alu_v, alu_z, alu_n, DI, brk_push, irq_n,
    input  P, C, D, I, irq_req
  );

  modport slave (
    input  cmd, sync, alu_co, alu_v, alu_z, alu_n, DI, brk_push, irq_n,
    output P, C, D, I, irq_req
  );
endinterface

// File: rtl/status_irq_mask.sv
// -----------------------------------------------------------------------------
// status_irq_mask
// Delayed interrupt mask and registered IRQ request.
//   clk, reset_n : clock, synchronous active-low reset
//   RDY          : clock enable, both registers hold when low
//   sync         : opcode-fetch marker; the mask samples I only on these edges
//   I            : architectural interrupt-disable flag (registered, pre-update)
//   irq_n        : level IRQ, active low, already synchronised
//   irq_req      : registered IRQ request
// -----------------------------------------------------------------------------
module status_irq_mask (
  input  logic clk,
  input  logic reset_n,
  input  logic RDY,
  input  logic sync,
  input  logic I,
  input  logic irq_n,
  output logic irq_req
);

  logic irq_mask_q, irq_mask_d;
  logic irq_req_q,  irq_req_d;

  // Next-state: the mask follows I only at opcode fetch, which delays the
  // effect of CLI/SEI/PLP by one instruction. I here is the registered value,
  // i.e. I before the same edge's command lands.
  always_comb begin
    irq_mask_d = irq_mask_q;
    irq_req_d  = irq_req_q;
    if (RDY) begin
      if (sync) begin
        irq_mask_d = I;
      end else begin
        irq_mask_d = irq_mask_q;
      end
      irq_req_d = ~irq_n & ~irq_mask_q;
    end else begin
      irq_mask_d = irq_mask_q;
      irq_req_d  = irq_req_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask_q <= 1'b1;
      irq_req_q  <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_req_q  <= irq_req_d;
    end
  end

  assign irq_req = irq_req_q;

endmodule

// File: rtl/status_reg.sv
// -----------------------------------------------------------------------------
// status_reg
// 6502 processor status (P) register. Captures registered ALU flags under
// sequencer command, feeds carry and decimal mode back into the ALU, builds
// the pushed P image and produces the IRQ request through the delayed mask.
//   clk, reset_n : clock, synchronous active-low reset
//   RDY          : clock enable, all state frozen when low
//   bus (slave)  : cmd, sync, alu_{co,v,z,n}, DI, brk_push, irq_n in;
//                  P, C, D, I, irq_req out
// Build option STATUS_CMOS_EN: INT also clears D and code E becomes a
// Z-only update (65C02). Undefined gives NMOS behaviour.
// -----------------------------------------------------------------------------
module status_reg
  import cpu_status_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         RDY,
  status_reg_if.slave  bus
);

  status_flags_t flags_q, flags_d;
  logic          di_unused;

  // DI[5:4] have no storage behind them; PLP discards them.
  assign di_unused = ^bus.DI[5:4];

  // Flag update decode, gated by RDY
  always_comb begin
    flags_d = flags_q;
    if (RDY) begin
      case (bus.cmd)
        CMD_NZ: begin
          flags_d.n = bus.alu_n;
          flags_d.z = bus.alu_z;
        end
        CMD_NZC: begin
          flags_d.n = bus.alu_n;
          flags_d.z = bus.alu_z;
          flags_d.c = bus.alu_co;
        end
        CMD_NZCV: begin
          flags_d.n = bus.alu_n;
          flags_d.z = bus.alu_z;
          flags_d.c = bus.alu_co;
          flags_d.v = bus.alu_v;
        end
        CMD_BIT: begin
          // N and V come straight from the memory operand, Z from the AND
          flags_d.z = bus.alu_z;
          flags_d.n = bus.DI[P_N];
          flags_d.v = bus.DI[P_V];
        end
        CMD_PLP: begin
          flags_d.n = bus.DI[P_N];
          flags_d.v = bus.DI[P_V];
          flags_d.d = bus.DI[P_D];
          flags_d.i = bus.DI[P_I];
          flags_d.z = bus.DI[P_Z];
          flags_d.c = bus.DI[P_C];
        end
        CMD_CLC: flags_d.c = 1'b0;
        CMD_SEC: flags_d.c = 1'b1;
        CMD_CLI: flags_d.i = 1'b0;
        CMD_SEI: flags_d.i = 1'b1;
        CMD_CLD: flags_d.d = 1'b0;
        CMD_SED: flags_d.d = 1'b1;
        CMD_CLV: flags_d.v = 1'b0;
        CMD_INT: begin
          flags_d.i = 1'b1;
`ifdef STATUS_CMOS_EN
          flags_d.d = 1'b0;
`else
          flags_d.d = flags_q.d;
`endif
        end
`ifdef STATUS_CMOS_EN
        CMD_ZONLY: flags_d.z = bus.alu_z;
`endif
        default: flags_d = flags_q;
      endcase
    end else begin
      flags_d = flags_q;
    end
  end

  // Flag storage with synchronous reset (reset dominates RDY and cmd)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q.n <= 1'b0;
      flags_q.v <= 1'b0;
      flags_q.d <= 1'b0;
      flags_q.i <= 1'b1;
      flags_q.z <= 1'b0;
      flags_q.c <= 1'b0;
    end else begin
      flags_q <= flags_d;
    end
  end

  status_irq_mask u_irq_mask (
    .clk     (clk),
    .reset_n (reset_n),
    .RDY     (RDY),
    .sync    (bus.sync),
    .I       (flags_q.i),
    .irq_n   (bus.irq_n),
    .irq_req (bus.irq_req)
  );

  assign bus.P = p_image(flags_q, bus.brk_push);
  assign bus.C = flags_q.c;
  assign bus.D = flags_q.d;
  assign bus.I = flags_q.i;

endmodule
